// File: rtl/sub_pipe_32bits.sv
// Two-stage pipelined subtractor D = A - B - Bin, computed as A + ~B + !Bin with
// Kogge-Stone carry prefixes per stage and valid/ready handshakes on both sides.

module sub_pipe_prefix_carry #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_g,
    input  logic [N-1:0] i_p,
    input  logic         i_cin,
    output logic [N:0]   o_c
);
    localparam int LEVELS = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;

    // Log-depth group generate/propagate; carry into bit i+1 is G[i:0] | P[i:0] & cin
    always_comb begin
        w_g = i_g;
        w_p = i_p;
        for (int l = 0; l < LEVELS; l++) begin
            // Walk downward so w_g[i-d] still holds the previous level's value
            for (int i = N - 1; i >= (1 << l); i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end
        o_c[0] = i_cin;
        for (int i = 0; i < N; i++) begin
            o_c[i + 1] = w_g[i] | (w_p[i] & i_cin);
        end
    end
endmodule

module sub_pipe_32bits #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             N
);
    localparam int HW = WIDTH - SPLIT;

    logic [SPLIT-1:0] w_lo_g;
    logic [SPLIT-1:0] w_lo_p;
    logic [SPLIT:0]   w_lo_c;
    logic [SPLIT-1:0] w_lo_d;
    logic [HW-1:0]    w_hi_g;
    logic [HW-1:0]    w_hi_p;
    logic [HW:0]      w_hi_c;
    logic [HW-1:0]    w_hi_d;
    logic [WIDTH-1:0] w_d;
    logic             w_v;
    logic             w_s1_adv;
    logic             w_s2_adv;

    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_dlo;
    logic             r_s1_c;
    logic [HW-1:0]    r_s1_ahi;
    logic [HW-1:0]    r_s1_nbhi;
    logic             r_s1_amsb;
    logic             r_s1_bmsb;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;
    logic             r_z;
    logic             r_n;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_lo_g = A[SPLIT-1:0] & ~B[SPLIT-1:0];
    assign w_lo_p = A[SPLIT-1:0] ^ ~B[SPLIT-1:0];

    sub_pipe_prefix_carry #(.N(SPLIT)) u_lo_carry (
        .i_g   (w_lo_g),
        .i_p   (w_lo_p),
        .i_cin (~Bin),
        .o_c   (w_lo_c)
    );

    assign w_lo_d = w_lo_p ^ w_lo_c[SPLIT-1:0];

    assign w_hi_g = r_s1_ahi & r_s1_nbhi;
    assign w_hi_p = r_s1_ahi ^ r_s1_nbhi;

    sub_pipe_prefix_carry #(.N(HW)) u_hi_carry (
        .i_g   (w_hi_g),
        .i_p   (w_hi_p),
        .i_cin (r_s1_c),
        .o_c   (w_hi_c)
    );

    assign w_hi_d = w_hi_p ^ w_hi_c[HW-1:0];
    assign w_d    = {w_hi_d, r_s1_dlo};
    assign w_v    = (r_s1_amsb != r_s1_bmsb) && (w_d[WIDTH-1] != r_s1_amsb);

    // Stage 1: low half difference, split carry and upper operand bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dlo   <= {SPLIT{1'b0}};
            r_s1_c     <= 1'b0;
            r_s1_ahi   <= {HW{1'b0}};
            r_s1_nbhi  <= {HW{1'b0}};
            r_s1_amsb  <= 1'b0;
            r_s1_bmsb  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_dlo  <= w_lo_d;
                r_s1_c    <= w_lo_c[SPLIT];
                r_s1_ahi  <= A[WIDTH-1:SPLIT];
                r_s1_nbhi <= ~B[WIDTH-1:SPLIT];
                r_s1_amsb <= A[WIDTH-1];
                r_s1_bmsb <= B[WIDTH-1];
            end else begin
                r_s1_dlo  <= r_s1_dlo;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: upper half, flags and the output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_d        <= {WIDTH{1'b0}};
            r_bout     <= 1'b0;
            r_v        <= 1'b0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_d    <= w_d;
                r_bout <= ~w_hi_c[HW];
                r_v    <= w_v;
                r_z    <= (w_d == {WIDTH{1'b0}});
                r_n    <= w_d[WIDTH-1];
            end else begin
                r_d    <= r_d;
            end
        end else begin
            r_s2_valid <= r_s2_valid;
        end
    end

    assign out_valid = r_s2_valid;
    assign D         = r_d;
    assign Bout      = r_bout;
    assign V         = r_v;
    assign Z         = r_z;
    assign N         = r_n;
endmodule

// File: tb/tb_sub_pipe_32bits.sv
// Directed and scoreboarded checks of sub_pipe_32bits: arithmetic, flags, streaming,
// backpressure and asynchronous reset with beats in flight.

module tb_sub_pipe_32bits;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        Z;
    logic        N;

    int n_tests = 0;
    int n_fail  = 0;

    sub_pipe_32bits #(.WIDTH(32), .SPLIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z),
        .N         (N)
    );

    always #5 clk = ~clk;

    // Reference: 33-bit subtraction, packed as {D, Bout, V, Z, N}
    function automatic logic [35:0] sub_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic bin);
        logic [32:0] diff;
        logic [31:0] d;
        logic        v;
        diff = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        d    = diff[31:0];
        v    = (a[31] != b[31]) && (d[31] != a[31]);
        return {d, diff[32], v, (d == 32'd0), d[31]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if ({D, Bout, V, Z, N} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {D, Bout, V, Z, N});
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        logic        vbin[8];
        logic [35:0] vexp[8];
        va   = '{32'h00000005, 32'h00000000, 32'h80000000, 32'h00010000,
                 32'h00001234, 32'h00000007, 32'hFFFFFFFF, 32'h7FFFFFFF};
        vb   = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h00000001,
                 32'h00001234, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        // {D, Bout V Z N}
        vexp = '{{32'h00000002, 4'b0000}, {32'hFFFFFFFF, 4'b1001},
                 {32'h7FFFFFFF, 4'b0100}, {32'h0000FFFF, 4'b0000},
                 {32'hFFFFFFFF, 4'b1001}, {32'h00000000, 4'b0010},
                 {32'h00000000, 4'b0010}, {32'h80000000, 4'b1101}};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            A = va[i];
            B = vb[i];
            Bin = vbin[i];
            step();
            in_valid = 1'b0;
            step();
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_valid[%0d]: got %b expected 1", i, out_valid);
            end
            n_tests++;
            if ({D, Bout, V, Z, N} !== vexp[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got D=%h BVZN=%b expected D=%h BVZN=%b",
                         i, D, {Bout, V, Z, N}, vexp[i][35:4], vexp[i][3:0]);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_drain[%0d]: got %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta[8];
        logic [31:0] tb_[8];
        logic        tbin[8];
        logic [35:0] texp[8];
        for (int i = 0; i < 8; i++) begin
            ta[i]   = $urandom;
            tb_[i]  = (i == 3) ? ta[i] : $urandom;
            tbin[i] = 1'($urandom_range(0, 1));
            texp[i] = sub_model(ta[i], tb_[i], tbin[i]);
        end
        out_ready = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || {D, Bout, V, Z, N} !== texp[c-2]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got v=%b %h expected v=1 %h",
                             c - 2, out_valid, {D, Bout, V, Z, N}, texp[c-2]);
                end
            end
            if (c < 8) begin
                in_valid = 1'b1;
                A = ta[c];
                B = tb_[c];
                Bin = tbin[c];
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[4];
        logic [31:0] pb[4];
        logic        pbin[4];
        logic [35:0] pexp[4];
        int k;
        int o;
        for (int i = 0; i < 4; i++) begin
            pa[i]   = $urandom;
            pb[i]   = $urandom;
            pbin[i] = 1'(i & 1);
            pexp[i] = sub_model(pa[i], pb[i], pbin[i]);
        end
        k = 0;
        o = 0;
        step();
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (k < 4) begin
                in_valid = 1'b1;
                A = pa[k];
                B = pb[k];
                Bin = pbin[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready_stall[%0d]: got %b expected 0", cyc, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                n_tests++;
                if (o >= 4) begin
                    n_fail++;
                    $display("FAIL bp_extra_beat: got beat %0d expected none", o);
                end else if ({D, Bout, V, Z, N} !== pexp[o]) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d] cyc %0d: got %h expected %h",
                             o, cyc, {D, Bout, V, Z, N}, pexp[o]);
                end
                if (out_ready) o++;
            end
            if (in_valid && in_ready) k++;
            step();
        end
        n_tests++;
        if (o !== 4 || k !== 4) begin
            n_fail++;
            $display("FAIL bp_counts: got out=%0d in=%0d expected out=4 in=4", o, k);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid = 1'b1;
        A = 32'd9;
        B = 32'd2;
        Bin = 1'b0;
        step();
        A = 32'd20;
        B = 32'd5;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || D !== 32'd7) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b D=%h expected v=1 D=00000007", out_valid, D);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || {D, Bout, V, Z, N} !== 36'd0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b %h expected v=0 0", out_valid, {D, Bout, V, Z, N});
        end
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_post[%0d]: got v=%b rdy=%b expected v=0 rdy=1",
                         c, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        step();
        step();
        test_backpressure();
        step();
        step();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
